// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between two requesters, the arbiter and the register file.
// Signal names match the arbiter's port list; the arbiter uses the slave modport.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int NREG = 1 << ADDR_W;

    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              rf_rw;
    logic [ADDR_W-1:0] rf_writereg;
    logic [DATA_W-1:0] rf_datawritten;
    logic              rf_grant_id;
    logic [NREG-1:0]   pend_mask;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output rf_rw, rf_writereg, rf_datawritten, rf_grant_id, pend_mask
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  rf_rw, rf_writereg, rf_datawritten, rf_grant_id, pend_mask
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter for the single register-file write port: one-entry slots,
// age-ordered with round-robin tie break. Define REGFILE_ARB_ZERO_DROP_EN to swallow writes to reg 0.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic                  clk,
    input logic                  rst_n,
    regfile_wb_arbiter_if.slave  wb
);
    localparam int NREG = 1 << ADDR_W;

    logic [1:0]              in_vld, keep, rdy, gnt, acc, fill, stay, full_d;
    logic [1:0][ADDR_W-1:0]  in_addr;
    logic [1:0][DATA_W-1:0]  in_data;

    logic [1:0]              full_q;
    logic [1:0][ADDR_W-1:0]  addr_q;
    logic [1:0][DATA_W-1:0]  data_q;
    // age_q = 1 means slot 1 was filled before slot 0; tie_q = both filled on the same edge
    logic                    age_q, age_d, tie_q, tie_d, rr_q, rr_d;

    logic                    rf_rw_q, rf_gid_q;
    logic [ADDR_W-1:0]       rf_addr_q;
    logic [DATA_W-1:0]       rf_data_q;
    logic [NREG-1:0]         pend;

    assign in_vld  = {wb.req1_valid, wb.req0_valid};
    assign in_addr = {wb.req1_addr,  wb.req0_addr};
    assign in_data = {wb.req1_data,  wb.req0_data};

    for (genvar i = 0; i < 2; i++) begin : g_keep
`ifdef REGFILE_ARB_ZERO_DROP_EN
        assign keep[i] = |in_addr[i];
`else
        assign keep[i] = 1'b1;
`endif
    end

    // Grant depends only on slot state, so ready never waits on valid.
    always_comb begin
        gnt    = '0;
        gnt[1] = full_q[1] & (~full_q[0] | (tie_q ? rr_q : age_q));
        gnt[0] = full_q[0] & ~gnt[1];
    end

    assign rdy    = ~full_q | gnt;
    assign acc    = in_vld & rdy;
    assign fill   = acc & keep;
    assign stay   = full_q & ~gnt;
    assign full_d = fill | stay;

    always_comb begin
        tie_d = tie_q;
        age_d = age_q;
        rr_d  = rr_q;
        if (&fill) begin
            tie_d = 1'b1;
        end else if (fill[0] & stay[1]) begin
            tie_d = 1'b0;
            age_d = 1'b1;
        end else if (fill[1] & stay[0]) begin
            tie_d = 1'b0;
            age_d = 1'b0;
        end
        if ((&full_q) & tie_q) rr_d = gnt[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= '0;
            addr_q <= '0;
            data_q <= '0;
            age_q  <= 1'b0;
            tie_q  <= 1'b0;
            rr_q   <= 1'b0;
        end else begin
            full_q <= full_d;
            age_q  <= age_d;
            tie_q  <= tie_d;
            rr_q   <= rr_d;
            for (int i = 0; i < 2; i++) begin
                if (fill[i]) begin
                    addr_q[i] <= in_addr[i];
                    data_q[i] <= in_data[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_rw_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            rf_gid_q  <= 1'b0;
        end else begin
            rf_rw_q <= |full_q;
            if (|full_q) begin
                rf_addr_q <= gnt[1] ? addr_q[1] : addr_q[0];
                rf_data_q <= gnt[1] ? data_q[1] : data_q[0];
                rf_gid_q  <= gnt[1];
            end
        end
    end

    // Anything queued or on the port is still in flight for the issue logic.
    always_comb begin
        pend = '0;
        for (int i = 0; i < 2; i++) begin
            if (full_q[i]) pend[addr_q[i]] = 1'b1;
        end
        if (rf_rw_q) pend[rf_addr_q] = 1'b1;
    end

    assign wb.req0_ready     = rdy[0];
    assign wb.req1_ready     = rdy[1];
    assign wb.rf_rw          = rf_rw_q;
    assign wb.rf_writereg    = rf_addr_q;
    assign wb.rf_datawritten = rf_data_q;
    assign wb.rf_grant_id    = rf_gid_q;
    assign wb.pend_mask      = pend;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: scoreboard of expected rf writes plus a negedge register-file model.
module tb_regfile_wb_arbiter;
    typedef struct {
        logic        id;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    wr_t  sb[$];
    logic [31:0] rf_m [32] = '{default: 32'h0};

    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set0(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.req0_valid = v;
        bus.req0_addr  = a;
        bus.req0_data  = d;
    endtask

    task automatic set1(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.req1_valid = v;
        bus.req1_addr  = a;
        bus.req1_data  = d;
    endtask

    task automatic push(input logic id, input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.id   = id;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    // Register file: captures on the negedge inside the rf_rw cycle.
    always @(negedge clk) begin
        if (bus.rf_rw) rf_m[bus.rf_writereg] <= bus.rf_datawritten;
    end

    // Every rf_rw pulse must match the next expected write, in order.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && bus.rf_rw) begin
            if (sb.size() == 0) begin
                chk("rf_unexpected", {63'd0, bus.rf_rw}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("rf_addr", {59'd0, bus.rf_writereg}, {59'd0, e.addr});
                chk("rf_data", {32'd0, bus.rf_datawritten}, {32'd0, e.data});
                chk("rf_gid", {63'd0, bus.rf_grant_id}, {63'd0, e.id});
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        set0(0, 0, 0);
        set1(0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rw", {63'd0, bus.rf_rw}, 64'd0);
        chk("rst_wreg", {59'd0, bus.rf_writereg}, 64'd0);
        chk("rst_wdata", {32'd0, bus.rf_datawritten}, 64'd0);
        chk("rst_gid", {63'd0, bus.rf_grant_id}, 64'd0);
        chk("rst_pend", {32'd0, bus.pend_mask}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("rst_rdy0", {63'd0, bus.req0_ready}, 64'd1);
        chk("rst_rdy1", {63'd0, bus.req1_ready}, 64'd1);
        cyc();

        // single stream from req0
        set0(1, 3, 32'h0000000A); push(0, 3, 32'h0000000A);
        smp(); chk("s_rdy0a", {63'd0, bus.req0_ready}, 64'd1);
        cyc();
        set0(1, 4, 32'h0000000B); push(0, 4, 32'h0000000B);
        smp(); chk("s_rdy0b", {63'd0, bus.req0_ready}, 64'd1);
        chk("s_pend0", {32'd0, bus.pend_mask}, 64'h8);
        cyc();
        set0(0, 0, 0);
        smp(); chk("s_pend1", {32'd0, bus.pend_mask}, 64'h18);
        cyc(); smp(); chk("s_pend2", {32'd0, bus.pend_mask}, 64'h10);
        cyc(); smp(); chk("s_idle_rw", {63'd0, bus.rf_rw}, 64'd0);
        chk("s_reg3", {32'd0, rf_m[3]}, 64'hA);
        chk("s_reg4", {32'd0, rf_m[4]}, 64'hB);
        cyc();

        // same-cycle tie, pointer at req0
        set0(1, 5, 32'h11); set1(1, 6, 32'h22);
        push(0, 5, 32'h11); push(1, 6, 32'h22);
        smp(); chk("t_rdy0", {63'd0, bus.req0_ready}, 64'd1);
        chk("t_rdy1", {63'd0, bus.req1_ready}, 64'd1);
        cyc();
        set0(0, 0, 0); set1(0, 0, 0);
        smp(); chk("t_rdy1_wait", {63'd0, bus.req1_ready}, 64'd0);
        chk("t_rdy0_gnt", {63'd0, bus.req0_ready}, 64'd1);
        chk("t_pend", {32'd0, bus.pend_mask}, 64'h60);
        cyc(); smp(); cyc(); smp(); cyc(); smp();
        chk("t_pend_clr", {32'd0, bus.pend_mask}, 64'd0);
        cyc();

        // second tie: pointer has moved to req1
        set0(1, 10, 32'h33); set1(1, 11, 32'h44);
        push(1, 11, 32'h44); push(0, 10, 32'h33);
        smp(); cyc();
        set0(0, 0, 0); set1(0, 0, 0);
        smp(); chk("t2_rdy0_wait", {63'd0, bus.req0_ready}, 64'd0);
        cyc(); smp(); cyc(); smp(); cyc();

        // age ordering with same-address collision
        set0(1, 7, 32'h7); set1(1, 8, 32'h2);
        push(0, 7, 32'h7); push(1, 8, 32'h2);
        smp(); cyc();
        set0(1, 8, 32'h1); set1(0, 0, 0); push(0, 8, 32'h1);
        smp(); chk("a_rdy0", {63'd0, bus.req0_ready}, 64'd1);
        chk("a_rdy1_wait", {63'd0, bus.req1_ready}, 64'd0);
        cyc();
        set0(0, 0, 0);
        smp(); chk("a_rdy1_gnt", {63'd0, bus.req1_ready}, 64'd1);
        chk("a_rdy0_wait", {63'd0, bus.req0_ready}, 64'd0);
        cyc(); smp(); cyc(); smp(); cyc(); smp();
        chk("a_reg8", {32'd0, rf_m[8]}, 64'h1);
        chk("a_pend", {32'd0, bus.pend_mask}, 64'd0);
        cyc();

        // pend_mask lifetime
        set1(1, 9, 32'h99); push(1, 9, 32'h99);
        cyc();
        set1(0, 0, 0);
        smp(); chk("p_pend_slot", {32'd0, bus.pend_mask}, 64'h200);
        cyc(); smp(); chk("p_pend_rf", {32'd0, bus.pend_mask}, 64'h200);
        cyc(); smp(); chk("p_pend_clr", {32'd0, bus.pend_mask}, 64'd0);
        cyc();

        // write to register 0
        set0(1, 0, 32'hDEAD);
`ifndef REGFILE_ARB_ZERO_DROP_EN
        push(0, 0, 32'hDEAD);
`endif
        smp(); chk("z_rdy0", {63'd0, bus.req0_ready}, 64'd1);
        cyc();
        set0(0, 0, 0);
        smp();
`ifdef REGFILE_ARB_ZERO_DROP_EN
        chk("z_pend", {32'd0, bus.pend_mask}, 64'd0);
`else
        chk("z_pend", {32'd0, bus.pend_mask}, 64'd1);
`endif
        cyc(); smp(); cyc(); smp();
`ifdef REGFILE_ARB_ZERO_DROP_EN
        chk("z_reg0", {32'd0, rf_m[0]}, 64'd0);
`else
        chk("z_reg0", {32'd0, rf_m[0]}, 64'hDEAD);
`endif
        cyc();

        // reset in the middle of a stream
        set0(1, 20, 32'h20); push(0, 20, 32'h20);
        cyc();
        set0(1, 21, 32'h21); push(0, 21, 32'h21);
        cyc();
        chk("r_rw_pre", {63'd0, bus.rf_rw}, 64'd1);
        rst_n = 1'b0;
        set0(0, 0, 0);
        #1;
        chk("r_rw", {63'd0, bus.rf_rw}, 64'd0);
        chk("r_pend", {32'd0, bus.pend_mask}, 64'd0);
        sb.delete();
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("r_rdy0", {63'd0, bus.req0_ready}, 64'd1);
        chk("r_rdy1", {63'd0, bus.req1_ready}, 64'd1);
        chk("r_gid", {63'd0, bus.rf_grant_id}, 64'd0);
        chk("r_wreg", {59'd0, bus.rf_writereg}, 64'd0);
        cyc();

        // pointer back at req0 after reset
        set0(1, 12, 32'h12); set1(1, 13, 32'h13);
        push(0, 12, 32'h12); push(1, 13, 32'h13);
        smp(); cyc();
        set0(0, 0, 0); set1(0, 0, 0);
        smp(); cyc(); smp(); cyc(); smp(); cyc(); smp();
        chk("r_reg20", {32'd0, rf_m[20]}, 64'd0);
        chk("r_reg21", {32'd0, rf_m[21]}, 64'd0);
        chk("r_reg12", {32'd0, rf_m[12]}, 64'h12);
        chk("r_reg13", {32'd0, rf_m[13]}, 64'h13);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
